// File: rtl/bkm_data_step_monitor.sv
// Downstream monitor for the BKM data step: converts CSD-coded X/Y back to
// two's complement, compares against expected values and keeps statistics.
module bkm_data_step_monitor #(
  parameter int W  = 64,
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            srst,
  input  logic            enable,
  input  logic [2*W-1:0]  X_np1_csd,
  input  logic [2*W-1:0]  Y_np1_csd,
  input  logic [W-1:0]    tb_exp_X,
  input  logic [W-1:0]    tb_exp_Y,
  output logic [W-1:0]    mon_X,
  output logic [W-1:0]    mon_Y,
  output logic            mon_valid,
  output logic            mismatch,
  output logic            err_sticky,
  output logic [CW-1:0]   sample_count,
  output logic [CW-1:0]   err_count,
  output logic [CW-1:0]   invalid_count
);

  // +1 flags of valid digits; a 2'b11 digit contributes to neither vector
  function automatic logic [W-1:0] csd_pos(input logic [2*W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i] = b[2*i+1] & ~b[2*i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] csd_neg(input logic [2*W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i] = ~b[2*i+1] & b[2*i];
    end
    return r;
  endfunction

  function automatic logic csd_has_invalid(input logic [2*W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < W; i++) begin
      r = r | (b[2*i+1] & b[2*i]);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    logic [CW-1:0] r;
    if (inc && (v != {CW{1'b1}})) begin
      r = v + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [2*W-1:0] x_csd_q, x_csd_d, y_csd_q, y_csd_d;
  logic [W-1:0]   exp_x1_q, exp_x1_d, exp_y1_q, exp_y1_d;
  logic           v1_q, v1_d;
  logic [W-1:0]   mon_x_q, mon_x_d, mon_y_q, mon_y_d;
  logic [W-1:0]   exp_x2_q, exp_x2_d, exp_y2_q, exp_y2_d;
  logic           inv2_q, inv2_d, v2_q, v2_d;
  logic           mismatch_q, mismatch_d, err_sticky_q, err_sticky_d;
  logic [CW-1:0]  sample_cnt_q, sample_cnt_d, err_cnt_q, err_cnt_d, inv_cnt_q, inv_cnt_d;
  logic           err_s;

  // Next-state logic for all three pipeline stages
  always_comb begin
    x_csd_d      = x_csd_q;
    y_csd_d      = y_csd_q;
    exp_x1_d     = exp_x1_q;
    exp_y1_d     = exp_y1_q;
    v1_d         = 1'b0;
    mon_x_d      = mon_x_q;
    mon_y_d      = mon_y_q;
    exp_x2_d     = exp_x2_q;
    exp_y2_d     = exp_y2_q;
    inv2_d       = inv2_q;
    v2_d         = v1_q;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    err_s        = (mon_x_q != exp_x2_q) | (mon_y_q != exp_y2_q) | inv2_q;

    if (enable) begin
      x_csd_d  = X_np1_csd;
      y_csd_d  = Y_np1_csd;
      exp_x1_d = tb_exp_X;
      exp_y1_d = tb_exp_Y;
      v1_d     = 1'b1;
    end else begin
      v1_d     = 1'b0;
    end

    // Plain modular subtraction; wrap-around is the intended result
    if (v1_q) begin
      mon_x_d  = csd_pos(x_csd_q) - csd_neg(x_csd_q);
      mon_y_d  = csd_pos(y_csd_q) - csd_neg(y_csd_q);
      exp_x2_d = exp_x1_q;
      exp_y2_d = exp_y1_q;
      inv2_d   = csd_has_invalid(x_csd_q) | csd_has_invalid(y_csd_q);
    end else begin
      inv2_d   = inv2_q;
    end

    if (v2_q) begin
      mismatch_d   = err_s;
      err_sticky_d = err_sticky_q | err_s;
      sample_cnt_d = sat_inc(sample_cnt_q, 1'b1);
      err_cnt_d    = sat_inc(err_cnt_q, err_s);
      inv_cnt_d    = sat_inc(inv_cnt_q, inv2_q);
    end else begin
      mismatch_d   = 1'b0;
    end
  end

  // State registers; srst clears exactly like arst
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      x_csd_q      <= '0;
      y_csd_q      <= '0;
      exp_x1_q     <= '0;
      exp_y1_q     <= '0;
      v1_q         <= 1'b0;
      mon_x_q      <= '0;
      mon_y_q      <= '0;
      exp_x2_q     <= '0;
      exp_y2_q     <= '0;
      inv2_q       <= 1'b0;
      v2_q         <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      inv_cnt_q    <= '0;
    end else if (srst) begin
      x_csd_q      <= '0;
      y_csd_q      <= '0;
      exp_x1_q     <= '0;
      exp_y1_q     <= '0;
      v1_q         <= 1'b0;
      mon_x_q      <= '0;
      mon_y_q      <= '0;
      exp_x2_q     <= '0;
      exp_y2_q     <= '0;
      inv2_q       <= 1'b0;
      v2_q         <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      inv_cnt_q    <= '0;
    end else begin
      x_csd_q      <= x_csd_d;
      y_csd_q      <= y_csd_d;
      exp_x1_q     <= exp_x1_d;
      exp_y1_q     <= exp_y1_d;
      v1_q         <= v1_d;
      mon_x_q      <= mon_x_d;
      mon_y_q      <= mon_y_d;
      exp_x2_q     <= exp_x2_d;
      exp_y2_q     <= exp_y2_d;
      inv2_q       <= inv2_d;
      v2_q         <= v2_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
    end
  end

  assign mon_X         = mon_x_q;
  assign mon_Y         = mon_y_q;
  assign mon_valid     = v2_q;
  assign mismatch      = mismatch_q;
  assign err_sticky    = err_sticky_q;
  assign sample_count  = sample_cnt_q;
  assign err_count     = err_cnt_q;
  assign invalid_count = inv_cnt_q;

endmodule

// File: tb/tb_bkm_data_step_monitor.sv
// Scoreboard bench for bkm_data_step_monitor with W=8; a second CW=4 instance
// shares the stimulus to exercise counter saturation.
module tb_bkm_data_step_monitor;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        srst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] X_np1_csd = 16'h0000;
  logic [15:0] Y_np1_csd = 16'h0000;
  logic [7:0]  tb_exp_X = 8'h00;
  logic [7:0]  tb_exp_Y = 8'h00;
  logic [7:0]  mon_X, mon_Y, s_mon_X, s_mon_Y;
  logic        mon_valid, mismatch, err_sticky;
  logic        s_mon_valid, s_mismatch, s_err_sticky;
  logic [31:0] sample_count, err_count, invalid_count;
  logic [3:0]  s_sample_count, s_err_count, s_invalid_count;

  bkm_data_step_monitor #(.W(8), .CW(32)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable),
    .X_np1_csd(X_np1_csd), .Y_np1_csd(Y_np1_csd),
    .tb_exp_X(tb_exp_X), .tb_exp_Y(tb_exp_Y),
    .mon_X(mon_X), .mon_Y(mon_Y), .mon_valid(mon_valid),
    .mismatch(mismatch), .err_sticky(err_sticky),
    .sample_count(sample_count), .err_count(err_count), .invalid_count(invalid_count));

  bkm_data_step_monitor #(.W(8), .CW(4)) dut_sat (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable),
    .X_np1_csd(X_np1_csd), .Y_np1_csd(Y_np1_csd),
    .tb_exp_X(tb_exp_X), .tb_exp_Y(tb_exp_Y),
    .mon_X(s_mon_X), .mon_Y(s_mon_Y), .mon_valid(s_mon_valid),
    .mismatch(s_mismatch), .err_sticky(s_err_sticky),
    .sample_count(s_sample_count), .err_count(s_err_count), .invalid_count(s_invalid_count));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] x; logic [7:0] y; logic err; } exp_t;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vld_seen = 0;
  logic chk_hold = 1'b1;
  logic pend_v = 1'b0;
  logic pend_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every mon_valid, checks mismatch one cycle later
  always @(posedge clk) begin
    #1;
    if (chk_hold) begin
      pend_v = 1'b0;
    end else begin
      check("mismatch", {31'd0, mismatch}, {31'd0, pend_v & pend_err});
      if (mon_valid) begin
        vld_seen++;
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_mon_valid: got 1, expected 0 at %0t", $time);
          pend_v = 1'b0;
        end else begin
          exp_t e;
          e = q.pop_front();
          check("mon_X", {24'd0, mon_X}, {24'd0, e.x});
          check("mon_Y", {24'd0, mon_Y}, {24'd0, e.y});
          pend_v   = 1'b1;
          pend_err = e.err;
        end
      end else begin
        pend_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [15:0] xc, input logic [15:0] yc, input logic [7:0] ex,
                      input logic [7:0] ey, input logic [7:0] mx, input logic [7:0] my,
                      input logic err);
    exp_t e;
    @(negedge clk);
    enable = 1'b1; X_np1_csd = xc; Y_np1_csd = yc; tb_exp_X = ex; tb_exp_Y = ey;
    e.x = mx; e.y = my; e.err = err;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag, input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] inv, input logic st);
    check({tag, "_sample_count"}, sample_count, s);
    check({tag, "_err_count"}, err_count, e);
    check({tag, "_invalid_count"}, invalid_count, inv);
    check({tag, "_err_sticky"}, {31'd0, err_sticky}, {31'd0, st});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mon_X"}, {24'd0, mon_X}, 32'd0);
    check({tag, "_mon_Y"}, {24'd0, mon_Y}, 32'd0);
    check({tag, "_mon_valid"}, {31'd0, mon_valid}, 32'd0);
    check({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
    check_counts(tag, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_srst();
    chk_hold = 1'b1;
    @(negedge clk);
    enable = 1'b0; srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    q.delete();
    chk_hold = 1'b0;
  endtask

  logic [15:0] clean_x [10] = '{16'h0002, 16'h0001, 16'h5555, 16'hAAAA, 16'h9999,
                                16'h0200, 16'h4000, 16'h0022, 16'h0000, 16'h0012};
  logic [7:0]  clean_m [10] = '{8'h01, 8'hFF, 8'h01, 8'hFF, 8'h55,
                                8'h10, 8'h80, 8'h05, 8'h00, 8'hFD};

  initial begin
    int v0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst = 1'b0;
    chk_hold = 1'b0;

    // Basic conversion, no error
    send(16'h0022, 16'h0012, 8'h05, 8'hFD, 8'h05, 8'hFD, 1'b0);
    idle(4);
    check_counts("t1", 32'd1, 32'd0, 32'd0, 1'b0);

    // Wrong expected Y, then sticky survives ten clean samples
    send(16'h0022, 16'h0012, 8'h05, 8'hFE, 8'h05, 8'hFD, 1'b1);
    idle(4);
    check_counts("t2a", 32'd2, 32'd1, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(clean_x[i], 16'h0012, clean_m[i], 8'hFD, clean_m[i], 8'hFD, 1'b0);
    end
    idle(4);
    check_counts("t2b", 32'd12, 32'd1, 32'd0, 1'b1);

    // Invalid digit reads as 0 but is still an error
    send(16'h0003, 16'h0022, 8'h00, 8'h05, 8'h00, 8'h05, 1'b1);
    idle(4);
    check_counts("t3", 32'd13, 32'd2, 32'd1, 1'b1);

    // Wrap to -128 and 20 back-to-back samples
    do_srst();
    check_all_zero("srst0");
    v0 = vld_seen;
    for (int i = 0; i < 20; i++) begin
      send(16'h8000, 16'h0000, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0);
    end
    idle(4);
    check("t4_valid_pulses", vld_seen - v0, 32'd20);
    check_counts("t4", 32'd20, 32'd0, 32'd0, 1'b0);

    // Async reset with erroring samples in flight
    chk_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(16'h0022, 16'h0000, 8'h77, 8'h00, 8'h05, 8'h00, 1'b1);
    end
    idle(1);
    @(posedge clk);
    #2 arst = 1'b1;
    #1 check_all_zero("arst_now");
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("arst_late_mismatch", {31'd0, mismatch}, 32'd0);
    end
    check_counts("arst_after", 32'd0, 32'd0, 32'd0, 1'b0);

    // Sync reset with samples in flight; srst beats a simultaneous enable
    for (int i = 0; i < 3; i++) begin
      send(16'h0022, 16'h0000, 8'h77, 8'h00, 8'h05, 8'h00, 1'b1);
    end
    @(negedge clk);
    srst = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 check_all_zero("srst_edge");
    @(negedge clk);
    srst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("srst_late_valid", {31'd0, mon_valid}, 32'd0);
      check("srst_late_mismatch", {31'd0, mismatch}, 32'd0);
    end
    check_counts("srst_after", 32'd0, 32'd0, 32'd0, 1'b0);
    q.delete();
    chk_hold = 1'b0;

    // Seventeen errors: 32-bit counters reach 17, 4-bit counters stop at 15
    do_srst();
    for (int i = 0; i < 17; i++) begin
      send(16'h0022, 16'h0012, 8'h06, 8'hFD, 8'h05, 8'hFD, 1'b1);
    end
    idle(4);
    check_counts("t6", 32'd17, 32'd17, 32'd0, 1'b1);
    check("t6_sat_sample_count", {28'd0, s_sample_count}, 32'd15);
    check("t6_sat_err_count", {28'd0, s_err_count}, 32'd15);
    check("t6_sat_err_sticky", {31'd0, s_err_sticky}, 32'd1);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bkm_data_step_monitor.md
Name: bkm_data_step_monitor

Overview:
Downstream transactor of the bkm_data_step block in the xfire_fpu_bkm verification environment. It samples the CSD-coded X_{n+1}/Y_{n+1} outputs of the data step and converts them back to W-bit two's-complement binary through a short pipeline. It compares the results against testbench-supplied expected values and keeps sample, error and invalid-digit statistics for the bench to read at end of test.

Parameters:
W, 64, binary word width; CSD buses are 2*W bits (W digits of 2 bits each).
CW, 32, width of the statistics counters.

Ports:
clk  in  1  system clock, all state on rising edge.
arst  in  1  asynchronous reset, active-high.
srst  in  1  synchronous reset, active-high; same clearing effect as arst at the next clk edge.
enable  in  1  sample strobe; inputs are captured on a clk edge where enable=1.
X_np1_csd  in  2*W  CSD X output of the data step.
Y_np1_csd  in  2*W  CSD Y output of the data step.
tb_exp_X  in  W  expected X (two's complement), aligned with X_np1_csd.
tb_exp_Y  in  W  expected Y (two's complement), aligned with Y_np1_csd.
mon_X  out  W  converted X.
mon_Y  out  W  converted Y.
mon_valid  out  1  mon_X/mon_Y hold a new result (one-cycle pulse per sample).
mismatch  out  1  one-cycle pulse: the compared sample had an error.
err_sticky  out  1  set on the first error, cleared only by reset.
sample_count  out  CW  number of samples compared.
err_count  out  CW  number of samples with an error.
invalid_count  out  CW  number of samples containing a 2'b11 digit.

Behaviour:
- Reset (arst async, or srst sync): every output and pipeline register is 0. Valid bits are cleared, so in-flight samples are discarded. srst has priority over enable.
- CSD digit i occupies bits [2i+1:2i]. Bit 2i+1 is the +1 flag and bit 2i is the -1 flag.
  - 2'b00 = 0, 2'b10 = +1, 2'b01 = -1.
  - 2'b11 is invalid and is treated as 0 in the arithmetic.
- Stage 1, capture cycle c: when enable=1, register both CSD buses, both expected values, and v1=1. When enable=0, v1=0 and the data registers hold their value.
- Stage 2, cycle c+1:
  - Split each bus into vectors P (the +1 flags) and N (the -1 flags), with invalid digits zeroed in both.
  - mon_X = P_X - N_X modulo 2^W; mon_Y likewise. Plain W-bit subtraction; wrap-around is intentional and unflagged.
  - inv2 = any 2'b11 digit in either bus.
  - mon_valid = v1. mon_X/mon_Y update only when v1=1, otherwise they hold.
- Stage 3, cycle c+2: when v2=1 (the delayed mon_valid):
  - err = (mon_X != exp_X) | (mon_Y != exp_Y) | inv2, with the expected values carried down the pipeline.
  - mismatch = err.
  - sample_count += 1; err_count += err; invalid_count += inv2.
  - err_sticky |= err.
- Latency: mon_valid rises 1 cycle after the capturing edge. mismatch and the counters update 2 cycles after it.
- Throughput: one sample per cycle; back-to-back enable is fully pipelined.
- Counters saturate at 2^CW-1 and never wrap.
- Reset asserted mid-operation: no mismatch pulse and no counter increment is produced for samples already in the pipe.
- enable asserted in the same cycle srst is released: srst still wins on that edge; capture begins on the following edge.

Test Plan:
1. W=8. enable=1 for one cycle with X_np1_csd=16'h0022 (+4+1) and tb_exp_X=8'h05, Y_np1_csd=16'h0012 (-4+1) and tb_exp_Y=8'hFD -> mon_valid pulse 1 cycle later with mon_X=8'h05, mon_Y=8'hFD; mismatch=0; sample_count=1, err_count=0.
2. Same stimulus with tb_exp_Y=8'hFE -> mismatch pulses 2 cycles after capture; err_count=1; err_sticky=1, and it stays 1 through 10 further clean samples.
3. X_np1_csd=16'h0003 (digit0=2'b11), tb_exp_X=0, Y valid and matching -> mon_X=0; invalid_count=1, err_count=1.
4. Digit7=+1 only (16'h8000) -> mon_X=8'h80 (wrap, -128) with no error when expected is 8'h80. 20 back-to-back samples -> 20 consecutive mon_valid pulses and sample_count=20.
5. Capture 3 samples, then assert arst asynchronously between clock edges one cycle later -> all outputs read 0 immediately. After release, no late mismatch pulse and sample_count stays 0. Repeat the sequence using srst -> outputs clear on the next edge.
6. CW=4, 17 erroring samples -> err_count and sample_count saturate at 4'hF.
